alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_pkg.sv | 24 ++
 rtl/alu_issue_regfile.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: supported opcodes, FSM state
// type and register-file sizing.
package alu_issue_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = $clog2(NUM_REGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WB
  } state_e;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// r0 hardwired to zero. Optional debug read port under ALU_ISSUE_DBG_EN.
module alu_issue_regfile
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [31:0]       ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [31:0]       rb_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [31:0]       wd
`ifdef ALU_ISSUE_DBG_EN
  ,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [31:0]       dbg_data
`endif
);

  logic [31:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs_q[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : regs_q[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs_q[rb_addr];

`ifdef ALU_ISSUE_DBG_EN
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
`endif

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue MIPS32 subset controller driving an external combinational ALU.
// Define ALU_ISSUE_DBG_EN to expose the dbg_addr/dbg_data register peek port.
//
// state   | meaning
// IDLE    | instr_ready high, waiting for a handshake
// ISSUE   | ALU operands driven; unsupported opcodes pulse illegal and return
// CAPTURE | ALU response sampled into writeback/branch registers
// WB      | wb_valid/branch_taken pulse, register write commits
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_func,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        branch_taken,
  output logic        illegal
`ifdef ALU_ISSUE_DBG_EN
  ,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
`endif
);

  state_e            state_q, state_d;
  logic [5:0]        alu_opcode_q, alu_opcode_d;
  logic [5:0]        alu_func_q, alu_func_d;
  logic [31:0]       alu_a_q, alu_a_d;
  logic [31:0]       alu_b_q, alu_b_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              is_beq_q, is_beq_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              branch_taken_q, branch_taken_d;
  logic              illegal_q, illegal_d;
  logic              rf_we;
  logic [31:0]       rs_data, rt_data;

  logic [5:0]  instr_op;
  logic [31:0] imm_sext;
  assign instr_op = instr[31:26];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  // Operands are read straight from the offered word so they land in ISSUE.
  alu_issue_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (instr[25:21]),
    .ra_data  (rs_data),
    .rb_addr  (instr[20:16]),
    .rb_data  (rt_data),
    .we       (rf_we),
    .wa       (wb_rd_q),
    .wd       (wb_data_q)
`ifdef ALU_ISSUE_DBG_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      alu_opcode_q   <= '0;
      alu_func_q     <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      dest_q         <= '0;
      is_beq_q       <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      branch_taken_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_func_q     <= alu_func_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      dest_q         <= dest_d;
      is_beq_q       <= is_beq_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      branch_taken_q <= branch_taken_d;
      illegal_q      <= illegal_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    alu_opcode_d   = alu_opcode_q;
    alu_func_d     = alu_func_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    dest_d         = dest_q;
    is_beq_d       = is_beq_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    branch_taken_d = 1'b0;
    illegal_d      = 1'b0;
    rf_we          = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          state_d = ISSUE;
          if (op_supported(instr_op)) begin
            alu_opcode_d = instr_op;
            alu_a_d      = rs_data;
            alu_b_d      = rt_data;
            alu_func_d   = '0;
            dest_d       = instr[20:16];
            is_beq_d     = 1'b0;
            case (instr_op)
              OP_RTYPE: begin
                alu_func_d = instr[5:0];
                dest_d     = instr[15:11];
              end
              OP_BEQ:  is_beq_d = 1'b1;
              default: alu_b_d  = imm_sext;
            endcase
          end else begin
            // ALU outputs are left untouched for unsupported opcodes.
            illegal_d = 1'b1;
          end
        end
      end
      ISSUE:   state_d = illegal_q ? IDLE : CAPTURE;
      CAPTURE: begin
        state_d = WB;
        if (is_beq_q) begin
          branch_taken_d = alu_zero;
        end else begin
          wb_valid_d = 1'b1;
          wb_rd_d    = dest_q;
          wb_data_d  = alu_result;
        end
      end
      WB: begin
        state_d = IDLE;
        rf_we   = wb_valid_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_ready  = (state_q == IDLE);
  assign alu_opcode   = alu_opcode_q;
  assign alu_func     = alu_func_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign branch_taken = branch_taken_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stand-in, timeline-based reference
// model checked every cycle, directed literal scenarios and randomized traffic.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  alu_opcode, alu_func;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        branch_taken, illegal;
`ifdef ALU_ISSUE_DBG_EN
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_opcode   (alu_opcode),
    .alu_func     (alu_func),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .branch_taken (branch_taken),
    .illegal      (illegal)
`ifdef ALU_ISSUE_DBG_EN
    ,
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
`endif
  );

  // MIPS ALU semantics shared by the ALU stand-in and the reference model.
  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [31:0] a, input logic [31:0] b);
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24:        return a & b;
        6'h25:        return a | b;
        6'h26:        return a ^ b;
        6'h27:        return ~(a | b);
        6'h2A:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B:        return (a < b) ? 32'd1 : 32'd0;
        default:      return 32'd0;
      endcase
    end else if (op == 6'h04) begin
      return a - b;
    end
    return a + b;
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_opcode, alu_func, alu_a, alu_b);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted instruction occupies cycles k=0 (ISSUE),
  // k=1 (CAPTURE), k=2 (WB) after its accept edge; illegal ones only k=0.
  logic [31:0] m_rf [32];
  int          cyc = 0;
  int          m_acc = 0;
  logic        started = 1'b0;
  logic        hs_seen = 1'b0;
  logic        m_active = 1'b0;
  logic        m_ill, m_wr, m_beq, m_taken;
  logic [4:0]  m_rd;
  logic [5:0]  m_op, m_fn;
  logic [31:0] m_a, m_b, m_res;
  logic        idle_before;
  int          k;

  task automatic model_accept(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    m_acc = cyc; m_active = 1'b1;
    m_ill = 1'b0; m_wr = 1'b0; m_beq = 1'b0; m_taken = 1'b0; m_rd = 5'd0;
    m_op = op; m_fn = 6'd0; m_a = m_rf[w[25:21]]; m_b = m_rf[w[20:16]];
    if (op == 6'h00) begin
      m_fn = w[5:0]; m_rd = w[15:11]; m_wr = 1'b1;
    end else if (op == 6'h08 || op == 6'h23) begin
      m_b = {{16{w[15]}}, w[15:0]}; m_rd = w[20:16]; m_wr = 1'b1;
    end else if (op == 6'h04) begin
      m_beq = 1'b1; m_taken = (m_a == m_b);
    end else begin
      m_ill = 1'b1;
    end
    m_res = alu_fn(m_op, m_fn, m_a, m_b);
  endtask

  always @(posedge clk) begin
    cyc++;
    hs_seen = 1'b0;
    idle_before = !m_active;
    if (rst) begin
      started = 1'b1;
      m_active = 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else if (started) begin
      if (m_active && ((cyc - m_acc) == (m_ill ? 1 : 3))) begin
        if (m_wr && m_rd != 5'd0) m_rf[m_rd] = m_res;
        m_active = 1'b0;
      end
      if (idle_before && instr_valid) begin
        hs_seen = 1'b1;
        model_accept(instr);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      k = cyc - m_acc;
      chk("instr_ready", 32'(instr_ready), 32'(!m_active));
      chk("illegal", 32'(illegal), 32'(m_active && m_ill && k == 0));
      chk("wb_valid", 32'(wb_valid), 32'(m_active && m_wr && k == 2));
      chk("branch_taken", 32'(branch_taken), 32'(m_active && m_beq && m_taken && k == 2));
      if (m_active && m_wr && k == 2) begin
        chk("wb_rd", 32'(wb_rd), 32'(m_rd));
        chk("wb_data", wb_data, m_res);
      end
      if (m_active && !m_ill && k <= 1) begin
        chk("alu_opcode", 32'(alu_opcode), 32'(m_op));
        chk("alu_func", 32'(alu_func), 32'(m_fn));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic wait_ready(input string nm);
    int guard;
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!instr_ready) chk({nm, "_ready_timeout"}, 32'(instr_ready), 32'd1);
  endtask

  task automatic issue(input string nm, input logic [31:0] ins, output logic got_wb,
                       output logic [4:0] rd, output logic [31:0] data,
                       output logic got_br, output logic got_ill, output int lat);
    got_wb = 1'b0; got_br = 1'b0; got_ill = 1'b0; rd = 5'd0; data = 32'd0; lat = -1;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    wait_ready(nm);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      if (wb_valid && !got_wb) begin
        got_wb = 1'b1; rd = wb_rd; data = wb_data; lat = n;
      end
      if (branch_taken) got_br = 1'b1;
      if (illegal) got_ill = 1'b1;
      if (n < 5) @(negedge clk);
    end
  endtask

  // kind: 0 writeback, 1 branch taken, 2 branch not taken, 3 illegal
  task automatic run(input string nm, input logic [31:0] ins, input int kind,
                     input logic [4:0] erd, input logic [31:0] edata);
    logic got_wb, got_br, got_ill;
    logic [4:0] rd;
    logic [31:0] data;
    int lat;
    issue(nm, ins, got_wb, rd, data, got_br, got_ill, lat);
    if (kind == 0) begin
      chk({nm, "_wb_valid"}, 32'(got_wb), 32'd1);
      chk({nm, "_wb_rd"}, 32'(rd), 32'(erd));
      chk({nm, "_wb_data"}, data, edata);
      chk({nm, "_latency"}, 32'(lat), 32'd3);
    end else if (kind == 3) begin
      chk({nm, "_illegal"}, 32'(got_ill), 32'd1);
      chk({nm, "_no_wb"}, 32'(got_wb), 32'd0);
      chk({nm, "_ready_back"}, 32'(instr_ready), 32'd1);
    end else begin
      chk({nm, "_no_wb"}, 32'(got_wb), 32'd0);
      chk({nm, "_taken"}, 32'(got_br), (kind == 1) ? 32'd1 : 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int sel;
    logic [5:0] op;
    logic [5:0] fn;
    sel = $urandom_range(0, 9);
    if (sel <= 3) begin
      case ($urandom_range(0, 9))
        0: fn = 6'h20; 1: fn = 6'h21; 2: fn = 6'h22; 3: fn = 6'h23; 4: fn = 6'h24;
        5: fn = 6'h25; 6: fn = 6'h26; 7: fn = 6'h27; 8: fn = 6'h2A; default: fn = 6'h2B;
      endcase
      return rtype(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), fn);
    end else if (sel <= 5) begin
      return itype(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
    end else if (sel == 6) begin
      return itype(6'h23, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
    end else if (sel <= 8) begin
      return itype(6'h04, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
    end
    do op = 6'($urandom_range(0, 63));
    while (op == 6'h00 || op == 6'h04 || op == 6'h08 || op == 6'h23);
    return {op, 26'($urandom)};
  endfunction

  initial begin
    int accepts, first_at, last_at;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_func", 32'(alu_func), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(instr_ready), 32'd1);

    run("addi_r1", itype(6'h08, 5'd0, 5'd1, 16'h2222), 0, 5'd1, 32'h0000_2222);
    run("addi_r2", itype(6'h08, 5'd0, 5'd2, 16'h1111), 0, 5'd2, 32'h0000_1111);
    run("add_r3", rtype(5'd1, 5'd2, 5'd3, 6'h20), 0, 5'd3, 32'h0000_3333);
    run("and_r4", rtype(5'd1, 5'd2, 5'd4, 6'h24), 0, 5'd4, 32'h0000_0000);
    run("slt_r5", rtype(5'd2, 5'd1, 5'd5, 6'h2A), 0, 5'd5, 32'h0000_0001);
    run("addi_r6", itype(6'h08, 5'd0, 5'd6, 16'h5555), 0, 5'd6, 32'h0000_5555);
    run("addi_r7", itype(6'h08, 5'd0, 5'd7, 16'h5555), 0, 5'd7, 32'h0000_5555);
    run("beq_eq", itype(6'h04, 5'd6, 5'd7, 16'h0004), 1, 5'd0, 32'd0);
    run("beq_ne", itype(6'h04, 5'd6, 5'd1, 16'h0004), 2, 5'd0, 32'd0);
    run("lw_r8", itype(6'h23, 5'd1, 5'd8, 16'h0010), 0, 5'd8, 32'h0000_2232);
    run("addi_negimm", itype(6'h08, 5'd1, 5'd10, 16'hFFFF), 0, 5'd10, 32'h0000_2221);
    run("addi_r0", itype(6'h08, 5'd0, 5'd0, 16'h0005), 0, 5'd0, 32'h0000_0005);
    run("r0_reads0", rtype(5'd0, 5'd0, 5'd9, 6'h20), 0, 5'd9, 32'd0);
    run("illegal_3f", {6'h3F, 26'h0}, 3, 5'd0, 32'd0);

    // Reset while an add sits in CAPTURE: no writeback, registers cleared.
    @(negedge clk);
    instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    instr_valid = 1'b1;
    wait_ready("rst_mid");
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("rst_mid_no_wb", 32'(wb_valid), 32'd0);
      @(negedge clk);
    end
    run("post_rst_r1r2", rtype(5'd1, 5'd2, 5'd11, 6'h20), 0, 5'd11, 32'd0);
    run("post_rst_r3r8", rtype(5'd3, 5'd8, 5'd12, 6'h25), 0, 5'd12, 32'd0);

    // instr_valid held high: one accept every 4 cycles.
    @(negedge clk);
    instr = itype(6'h08, 5'd1, 5'd1, 16'h0001);
    instr_valid = 1'b1;
    wait_ready("stream");
    accepts = 0; first_at = -1; last_at = -1;
    for (int n = 0; n < 40; n++) begin
      if (instr_valid && instr_ready) begin
        if (first_at < 0) first_at = n;
        last_at = n;
        accepts++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("stream_accepts", 32'(accepts), 32'd10);
    chk("stream_first", 32'(first_at), 32'd0);
    chk("stream_last", 32'(last_at), 32'd36);
    repeat (6) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      if (hs_seen || !instr_valid) begin
        instr_valid = ($urandom_range(0, 3) != 0);
        instr = rand_instr();
      end
      if ($urandom_range(0, 149) == 0) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
